// File: rtl/add_packetizer_if.sv
// add_packetizer_if: user-side and BFT-side signals of the add_packetizer.
//
// User side:
//   din_leaf_user2interface  payload word from the add_2_1 operator
//   vld_user2interface       payload valid
//   ack_interface2user       payload accepted this cycle
// BFT side:
//   dout_leaf_interface2bft  {valid, leaf, port, addr, payload} packet
//   bft_ready                switch takes the presented packet
//   credit_return            one-cycle pulse returning one credit
//   resend                   replay request for the last transferred packet
//
// Modports: slave is the packetizer, master is its environment
// (the user logic plus the BFT switch).
interface add_packetizer_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PACKET_BITS  = 49
);
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
  logic                    bft_ready;
  logic                    credit_return;
  logic                    resend;

  modport master (
    output din_leaf_user2interface, vld_user2interface,
    output bft_ready, credit_return, resend,
    input  ack_interface2user, dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface,
    input  bft_ready, credit_return, resend,
    output ack_interface2user, dout_leaf_interface2bft
  );
endinterface

// File: rtl/add_packetizer.sv
// add_packetizer: wraps add_2_1 result words into BFT packets.
//
// Words enter a 2-entry FIFO (ack = FIFO not full). A three-state FSM moves
// the FIFO head into the output packet register when a credit is available;
// the packet is held until bft_ready takes it. Packets carry a 7-bit
// sequence address that counts transferred packets and wraps.
//
// Ports:
//   clk_bft    single clock, rising edge
//   reset      asynchronous, active-low
//   dest_leaf  static destination leaf
//   dest_port  static destination port
//   bus        add_packetizer_if.slave (user and BFT handshakes)
//
// Optional feature: define PACKETIZER_RESEND_EN to add the replay register.
// A resend pulse then re-presents the last transferred packet before any new
// one, without consuming a credit. Without the macro, resend is ignored.
module add_packetizer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int CREDIT_INIT   = 64
) (
  input  logic                     clk_bft,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  add_packetizer_if.slave          bus
);

  localparam int CREDIT_BITS = $clog2(CREDIT_INIT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_CREDIT} state_t;

  state_t                   state, state_next, after_free;
  logic [PAYLOAD_BITS-1:0]  fifo_mem [2];
  logic                     fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]               fifo_count;
  logic [CREDIT_BITS-1:0]   credit, credit_next;
  logic [NUM_ADDR_BITS-1:0] addr;
  logic [PACKET_BITS-1:0]   dout_q, replay_pkt;
  logic fifo_full, fifo_empty, push, xfer, slot_free;
  logic load_new, load_replay, replay_req, credit_dec;

  assign fifo_full  = (fifo_count == 2'd2);
  assign fifo_empty = (fifo_count == 2'd0);
  // ack is forced low while reset is held.
  assign bus.ack_interface2user = reset & ~fifo_full;
  assign push      = bus.vld_user2interface & bus.ack_interface2user;
  assign xfer      = (state == SEND) & bus.bft_ready;
  // The packet register can take a new packet this cycle.
  assign slot_free = (state != SEND) | xfer;
  assign bus.dout_leaf_interface2bft = dout_q;

`ifdef PACKETIZER_RESEND_EN
  logic [PACKET_BITS-1:0] last_pkt;
  logic have_last, resend_pending, pres_replay;

  // A replay never costs a credit; only new packets decrement.
  assign credit_dec = xfer & ~pres_replay;
  // If a new packet is leaving right now, it is the one to replay.
  assign replay_pkt = credit_dec ? dout_q : last_pkt;
  assign replay_req = (have_last | credit_dec) & (resend_pending | bus.resend);

  always_ff @(posedge clk_bft or negedge reset) begin
    if (!reset) begin
      last_pkt       <= '0;
      have_last      <= 1'b0;
      resend_pending <= 1'b0;
      pres_replay    <= 1'b0;
    end else begin
      if (credit_dec) begin
        last_pkt  <= dout_q;
        have_last <= 1'b1;
      end
      if (slot_free) pres_replay <= load_replay;
      resend_pending <= replay_req & ~load_replay;
    end
  end
`else
  logic unused_resend;
  assign unused_resend = bus.resend;
  assign credit_dec    = xfer;
  assign replay_pkt    = '0;
  assign replay_req    = 1'b0;
`endif

  // Credit after this cycle's transfer and return; used by the FSM so a
  // return pulse in WAIT_CREDIT (or alongside the last transfer) is seen
  // immediately.
  always_comb begin
    credit_next = credit;
    if (credit_dec && !bus.credit_return) begin
      if (credit != '0) credit_next = credit - CREDIT_BITS'(1);
    end else if (!credit_dec && bus.credit_return) begin
      if (credit != CREDIT_BITS'(CREDIT_INIT)) credit_next = credit + CREDIT_BITS'(1);
    end
  end

  assign load_replay = slot_free & replay_req;
  assign load_new    = slot_free & ~replay_req & ~fifo_empty & (credit_next != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_next = state;
    if (load_new || load_replay)  after_free = SEND;
    else if (credit_next == '0)   after_free = WAIT_CREDIT;
    else                          after_free = IDLE;
    case (state)
      IDLE, WAIT_CREDIT: state_next = after_free;
      SEND:              if (xfer) state_next = after_free;
      default:           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_bft or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk_bft or negedge reset) begin
    if (!reset) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
      credit      <= CREDIT_BITS'(CREDIT_INIT);
      addr        <= '0;
      dout_q      <= '0;
    end else begin
      if (push)     fifo_wr_ptr <= ~fifo_wr_ptr;
      if (load_new) fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({push, load_new})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      credit <= credit_next;
      if (load_new) begin
        dout_q <= {1'b1, dest_leaf, dest_port, addr, fifo_mem[fifo_rd_ptr]};
        addr   <= addr + NUM_ADDR_BITS'(1);
      end else if (load_replay) begin
        dout_q <= replay_pkt;
      end else if (xfer) begin
        dout_q <= '0;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count
  // define which entries are live, so clearing them empties the FIFO.
  always_ff @(posedge clk_bft) begin
    if (push) fifo_mem[fifo_wr_ptr] <= bus.din_leaf_user2interface;
  end

endmodule
